switch_debouncer: RTL and testbench
===================================

Name: switch_debouncer

Overview:
- Input-side conditioner for the board slide switches and buttons.
- Takes raw asynchronous switch levels and produces synchronized, debounced levels plus one-cycle rise/fall pulses.
- Its outputs drive the switch inputs of the combinational LED logic, so that logic only ever sees clean, glitch-free levels.
- Sits between the top-level pins and the LED-driving logic.

Parameters:
- WIDTH, 8: number of switch bits conditioned in parallel.
- DEBOUNCE_CYCLES, 1000000: consecutive stable clocks required before a new level is accepted (10 ms at 100 MHz). Must be >= 2.
- CNT_WIDTH, 20: width of each per-bit counter. Must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- switch  input  WIDTH  raw asynchronous switch/button levels from pins.
- switch_clean  output  WIDTH  debounced switch levels.
- rise  output  WIDTH  one-cycle pulse per bit when switch_clean goes 0->1.
- fall  output  WIDTH  one-cycle pulse per bit when switch_clean goes 1->0.
- changed  output  1  OR-reduction of (rise | fall), registered with them.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge) clears everything to 0: sync stages, counters, switch_clean, rise, fall, changed. This applies mid-count as well, and any in-progress count is discarded.
- Synchronizer: two flops per bit, switch -> s1 -> s2. Only s2 is used downstream.
- Per-bit FSM, two states:
  - STABLE (s2 == switch_clean): cnt <= 0.
  - COUNTING (s2 != switch_clean):
    - If cnt == DEBOUNCE_CYCLES-1: switch_clean <= s2, cnt <= 0, and pulse rise (new value 1) or fall (new value 0) for exactly one cycle.
    - Otherwise: cnt <= cnt+1.
  - If s2 returns to switch_clean before acceptance, cnt <= 0 the same edge. A glitch of fewer than DEBOUNCE_CYCLES cycles at s2 is fully rejected.
- Latency:
  - A level change applied before edge k, held steady, appears on switch_clean after edge k+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges.
  - rise/fall assert in the same cycle switch_clean changes and deassert the next cycle.
- Bits are fully independent. Simultaneous changes on several bits produce simultaneous pulses. changed is high for one cycle if any bit pulses.
- The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- A switch held at 1 through reset release is treated as a fresh 0->1 change: rise pulses DEBOUNCE_CYCLES+2 edges after the first non-reset edge.
- rise and fall for the same bit are never high in the same cycle.
- A new change may start counting the cycle after acceptance. Minimum spacing between pulses on one bit is DEBOUNCE_CYCLES cycles.

Optional Feature:
- Macro: SWITCH_DEBOUNCE_TOGGLE_EN.
- Defined:
  - Adds output port toggle, WIDTH bits, reset 0.
  - Each toggle bit inverts on the edge after its rise pulse, turning push-buttons into latched on/off controls.
  - fall has no effect on toggle.
- Undefined: the toggle port and its register are absent, and all other behaviour is identical.

Test Plan:
All tests use DEBOUNCE_CYCLES=4.
- Reset: hold rst=1 for 3 cycles with switch=8'hFF -> switch_clean=8'h00, rise=fall=0, changed=0 during reset. After release, rise=8'hFF for one cycle exactly 6 edges after the first non-reset edge, then switch_clean=8'hFF.
- Clean step: switch 8'h00->8'h01 before edge k -> switch_clean=8'h01 and rise=8'h01, changed=1 after edge k+5, only. fall=0 throughout.
- Glitch rejection: switch[3] high for 3 cycles then low -> switch_clean stays 8'h00, with no rise/fall/changed pulses.
- Bounce then settle: switch[0] toggles 0,1,0,1 on consecutive cycles, then holds 1 -> exactly one rise[0] pulse, 6 edges after the final 0->1 transition.
- Simultaneous mixed: from 8'h0F, switch -> 8'hF0 -> after 6 edges rise=8'hF0 and fall=8'h0F in the same single cycle, changed=1.
- Reset mid-count: switch[5] 0->1, assert rst after 3 edges -> no pulse, switch_clean=0. After release with switch[5] still 1, rise[5] fires 6 edges later.
- With SWITCH_DEBOUNCE_TOGGLE_EN, two clean presses on bit 2 -> toggle[2] goes 0->1->0, each one edge after its rise[2] pulse.

Source files
------------

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - two-flop synchronizer and per-bit debounce with edge pulses
//
// Purpose: conditions raw switch/button pins into clean levels for downstream logic.
//   Each bit is synchronized through s1 -> s2 first. The bit is then accepted as
//   switch_clean only after s2 has differed from it for DEBOUNCE_CYCLES consecutive clocks.
//   rise and fall pulse for one cycle when a bit is accepted.
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   switch        raw asynchronous levels [WIDTH]
//   switch_clean  debounced levels [WIDTH]
//   rise / fall   one-cycle 0->1 / 1->0 acceptance pulses [WIDTH]
//   changed       OR of rise|fall, registered alongside them
//   toggle        (only with SWITCH_DEBOUNCE_TOGGLE_EN) inverts the edge after each rise
// Optional feature macro: SWITCH_DEBOUNCE_TOGGLE_EN
module switch_debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switch,
    output logic [WIDTH-1:0] switch_clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    ,
    output logic [WIDTH-1:0] toggle
`endif
);

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } db_state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]     s1;
    logic [WIDTH-1:0]     s2;
    logic [CNT_WIDTH-1:0] cnt      [WIDTH];
    logic [CNT_WIDTH-1:0] cnt_next [WIDTH];
    db_state_t            state    [WIDTH];
    logic [WIDTH-1:0]     clean_next;
    logic [WIDTH-1:0]     rise_next;
    logic [WIDTH-1:0]     fall_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1           <= '0;
            s2           <= '0;
            switch_clean <= '0;
            rise         <= '0;
            fall         <= '0;
            changed      <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1           <= switch;
            s2           <= s1;
            switch_clean <= clean_next;
            rise         <= rise_next;
            fall         <= fall_next;
            changed      <= |(rise_next | fall_next);
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // The accepted level is the FSM state register: a bit is COUNTING whenever the
    // synchronized input disagrees with it. Returning to agreement drops back to STABLE
    // and clears the count on the same edge, so short glitches leave no trace.
    always_comb begin
        clean_next = switch_clean;
        rise_next  = '0;
        fall_next  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            state[i]    = (s2[i] != switch_clean[i]) ? COUNTING : STABLE;
            case (state[i])
                STABLE: begin
                    cnt_next[i] = '0;
                end
                COUNTING: begin
                    if (cnt[i] == CNT_LAST) begin
                        clean_next[i] = s2[i];
                        rise_next[i]  = s2[i];
                        fall_next[i]  = ~s2[i];
                    end else begin
                        cnt_next[i] = cnt[i] + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    cnt_next[i] = '0;
                end
            endcase
        end
    end

`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    // Uses the registered rise, so each toggle bit flips the edge after its pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            toggle <= '0;
        end else begin
            toggle <= toggle ^ rise;
        end
    end
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - self-checking bench for switch_debouncer
module tb_switch_debouncer;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] switch = '0;
    logic [W-1:0] switch_clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    logic [W-1:0] toggle;
`endif

    int checks = 0;
    int errors = 0;

    switch_debouncer #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .CNT_WIDTH(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .switch(switch),
        .switch_clean(switch_clean),
        .rise(rise),
        .fall(fall),
        .changed(changed)
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
        ,
        .toggle(toggle)
`endif
    );

    always #5 clk = ~clk;

    // Reference model. The pin level reaches the debouncer two edges late. A bit is
    // accepted at an edge when the last D synchronized samples all agree and differ
    // from the current clean level.
    logic [W-1:0] sw_d1 = '0, sw_d2 = '0;
    logic [W-1:0] hist [D];
    logic [W-1:0] e_clean = '0, e_rise = '0, e_fall = '0, e_tog = '0;
    logic         e_changed = 1'b0;
    logic         model_valid = 1'b0;
    logic         all1, all0;

    always @(posedge clk) begin
        if (rst) begin
            sw_d1 = '0; sw_d2 = '0;
            for (int i = 0; i < D; i++) hist[i] = '0;
            e_clean = '0; e_rise = '0; e_fall = '0; e_tog = '0; e_changed = 1'b0;
        end else begin
            e_tog = e_tog ^ e_rise;
            for (int i = D - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = sw_d2;
            e_rise = '0; e_fall = '0;
            for (int b = 0; b < W; b++) begin
                all1 = 1'b1; all0 = 1'b1;
                for (int i = 0; i < D; i++) begin
                    if (hist[i][b]) all0 = 1'b0; else all1 = 1'b0;
                end
                if (all1 && !e_clean[b]) begin
                    e_clean[b] = 1'b1; e_rise[b] = 1'b1;
                end else if (all0 && e_clean[b]) begin
                    e_clean[b] = 1'b0; e_fall[b] = 1'b1;
                end
            end
            e_changed = |(e_rise | e_fall);
            sw_d2 = sw_d1;
            sw_d1 = switch;
        end
        model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if ({switch_clean, rise, fall, changed} !== {e_clean, e_rise, e_fall, e_changed}) begin
                errors++;
                $display("FAIL model t=%0t clean/rise/fall/changed got %h/%h/%h/%b want %h/%h/%h/%b",
                         $time, switch_clean, rise, fall, changed, e_clean, e_rise, e_fall, e_changed);
            end
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
            checks++;
            if (toggle !== e_tog) begin
                errors++;
                $display("FAIL model_toggle t=%0t got %h want %h", $time, toggle, e_tog);
            end
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Called right after a change is driven at a negedge; the pulse must land on the
    // n-th following negedge and nowhere before it.
    task automatic expect_pulse(input string name, input logic [W-1:0] er,
                                input logic [W-1:0] ef, input int n);
        int early = 0;
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            if (changed) early++;
        end
        @(negedge clk);
        chk({name, "_early"}, early, 0);
        chk({name, "_rise"}, rise, er);
        chk({name, "_fall"}, fall, ef);
        chk({name, "_changed"}, changed, 1);
        @(negedge clk);
        chk({name, "_after"}, {rise, fall, 7'b0, changed}, 0);
    endtask

    task automatic do_reset(input logic [W-1:0] val);
        @(negedge clk);
        rst = 1'b1; switch = val;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    int pulses;
    int hold;

    initial begin
        // Reset with all switches high, then release.
        @(negedge clk);
        rst = 1'b1; switch = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            chk("rst_state", {switch_clean, rise, fall, 7'b0, changed}, 0);
        end
        rst = 1'b0;
        expect_pulse("rst_release", 8'hFF, 8'h00, 6);
        chk("rst_clean", switch_clean, 8'hFF);

        // Clean step.
        do_reset(8'h00);
        repeat (8) @(negedge clk);
        switch = 8'h01;
        expect_pulse("step", 8'h01, 8'h00, 6);
        chk("step_clean", switch_clean, 8'h01);

        // Glitch of three cycles.
        do_reset(8'h00);
        repeat (8) @(negedge clk);
        switch = 8'h08;
        repeat (3) @(negedge clk);
        switch = 8'h00;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (changed || rise != 0 || fall != 0) pulses++;
        end
        chk("glitch_pulses", pulses, 0);
        chk("glitch_clean", switch_clean, 8'h00);

        // Bounce then settle.
        do_reset(8'h00);
        repeat (8) @(negedge clk);
        switch = 8'h00; @(negedge clk);
        switch = 8'h01; @(negedge clk);
        switch = 8'h00; @(negedge clk);
        switch = 8'h01;
        expect_pulse("bounce", 8'h01, 8'h00, 6);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (rise[0]) pulses++;
        end
        chk("bounce_extra", pulses, 0);

        // Simultaneous mixed change.
        do_reset(8'h0F);
        expect_pulse("pre_mixed", 8'h0F, 8'h00, 6);
        repeat (3) @(negedge clk);
        switch = 8'hF0;
        expect_pulse("mixed", 8'hF0, 8'h0F, 6);
        chk("mixed_clean", switch_clean, 8'hF0);

        // Reset in the middle of a count.
        do_reset(8'h00);
        repeat (8) @(negedge clk);
        switch = 8'h20;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_state", {switch_clean, rise, 8'b0}, 0);
        rst = 1'b0;
        expect_pulse("midrst", 8'h20, 8'h00, 6);

`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
        do_reset(8'h00);
        repeat (8) @(negedge clk);
        chk("tog_init", toggle, 8'h00);
        switch = 8'h04;
        expect_pulse("press1", 8'h04, 8'h00, 6);
        chk("tog_on", toggle, 8'h04);
        switch = 8'h00;
        expect_pulse("release1", 8'h00, 8'h04, 6);
        chk("tog_hold", toggle, 8'h04);
        switch = 8'h04;
        expect_pulse("press2", 8'h04, 8'h00, 6);
        chk("tog_off", toggle, 8'h00);
`endif

        // Randomized phase against the model: mixes long holds, short glitches and
        // occasional resets.
        do_reset(8'h00);
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 249) == 0);
            if (hold == 0) begin
                switch = switch ^ (W'($urandom) & W'($urandom));
                hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 14);
            end else begin
                hold--;
            end
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
